// File: rtl/pc_fetch.sv
// pc_fetch: fetch-side program counter unit for the waverv core.
// Owns the PC, issues one instruction-memory request at a time over a
// valid/ready handshake, presents the returned instruction with its PC to
// decode, handles redirects (discarding stale responses) and diverts
// misaligned redirect targets to TRAP_VECTOR.
//
// Parameters: XLEN (PC/address width), RESET_VECTOR, TRAP_VECTOR.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   stall                blocks issue of a new request
//   redirect_valid/_target  branch/jump taken, new PC
//   imem_req_valid/_ready/_addr  instruction fetch request channel
//   imem_rsp_valid/_data         fetch response (always accepted)
//   inst_valid/_ready/_data/_pc  instruction handed to decode
//   misalign_trap, trap_pc       one-cycle trap pulse, offending target
// Build option: define WAVERV_RVC_EN to allow halfword-aligned PCs and
// compressed (+2) PC advance.
module pc_fetch #(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = 'h0,
  parameter logic [XLEN-1:0]   TRAP_VECTOR  = 'h100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            misalign_trap,
  output logic [XLEN-1:0] trap_pc
);

  typedef enum logic [1:0] {FETCH, WAIT, DRAIN, DELIVER} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;
  logic [31:0]     inst_data_q, inst_data_d;
  logic            req_valid_q, req_valid_d;
  logic            trap_q, trap_d;
  logic            misaligned;
  logic [XLEN-1:0] pc_step;

`ifdef WAVERV_RVC_EN
  assign misaligned    = redirect_target[0];
  assign pc_step       = (imem_rsp_data[1:0] != 2'b11) ? XLEN'(2) : XLEN'(4);
  assign imem_req_addr = pc_q;
`else
  assign misaligned    = |redirect_target[1:0];
  assign pc_step       = XLEN'(4);
  assign imem_req_addr = {pc_q[XLEN-1:2], 2'b00};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_VECTOR;
      inst_pc_q   <= '0;
      trap_pc_q   <= '0;
      inst_data_q <= 32'h0000_0013;
      req_valid_q <= 1'b0;
      trap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_pc_q   <= inst_pc_d;
      trap_pc_q   <= trap_pc_d;
      inst_data_q <= inst_data_d;
      req_valid_q <= req_valid_d;
      trap_q      <= trap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_pc_d   = inst_pc_q;
    trap_pc_d   = trap_pc_q;
    inst_data_d = inst_data_q;
    req_valid_d = req_valid_q;
    trap_d      = 1'b0;

    if (redirect_valid) begin
      // Redirect overrides everything; a request already accepted in WAIT
      // still owes us a response, which DRAIN swallows.
      req_valid_d = 1'b0;
      if (misaligned) begin
        pc_d      = TRAP_VECTOR;
        trap_d    = 1'b1;
        trap_pc_d = redirect_target;
      end else begin
        pc_d = redirect_target;
      end
      state_d = (state_q == WAIT && !imem_rsp_valid) ? DRAIN : FETCH;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (req_valid_q && imem_req_ready) begin
            req_valid_d = 1'b0;
            state_d     = WAIT;
          end else begin
            req_valid_d = req_valid_q | ~stall;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            inst_data_d = imem_rsp_data;
            inst_pc_d   = pc_q;
            pc_d        = pc_q + pc_step;
            state_d     = DELIVER;
          end
        end
        DELIVER: begin
          // Raise the next request on the way back to FETCH so it can be
          // accepted in the first FETCH cycle (3-cycle loop).
          if (inst_ready) begin
            state_d     = FETCH;
            req_valid_d = ~stall;
          end
        end
        DRAIN: begin
          if (imem_rsp_valid) begin
            state_d     = FETCH;
            req_valid_d = ~stall;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  assign imem_req_valid = req_valid_q;
  assign inst_valid     = (state_q == DELIVER);
  assign inst_data      = inst_data_q;
  assign inst_pc        = inst_pc_q;
  assign misalign_trap  = trap_q;
  assign trap_pc        = trap_pc_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: self-checking bench for pc_fetch (XLEN=32, RESET_VECTOR='h80).
// A bench-side PC model predicts every fetch address; accepted requests push
// {pc, data} into a scoreboard queue, delivered instructions pop and compare.
// Honours WAVERV_RVC_EN for the compressed-advance and alignment behaviour.
module tb_pc_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        misalign_trap;
  logic [31:0] trap_pc;

  pc_fetch #(
    .XLEN        (32),
    .RESET_VECTOR(32'h80),
    .TRAP_VECTOR (32'h100)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .misalign_trap  (misalign_trap),
    .trap_pc        (trap_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] model_pc;
  logic [31:0] mem_data;
  bit          auto_rsp, drop_next, pend, acc, popped;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] step_of(input logic [31:0] d);
`ifdef WAVERV_RVC_EN
    return (d[1:0] != 2'b11) ? 32'd2 : 32'd4;
`else
    return 32'd4;
`endif
  endfunction

  // Sample at the falling edge: scoreboard pop on delivery, push on accept.
  task automatic smp();
    logic [63:0] e;
    @(negedge clk);
    acc    = imem_req_valid && imem_req_ready;
    popped = 1'b0;
    if (inst_valid && inst_ready) begin
      if (sb_q.size() == 0) begin
        check("stale_inst", {32'b0, inst_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        check("inst_pc", {32'b0, inst_pc}, {32'b0, e[63:32]});
        check("inst_data", {32'b0, inst_data}, {32'b0, e[31:0]});
        popped = 1'b1;
      end
    end
    if (acc) begin
      check("req_addr", {32'b0, imem_req_addr}, {32'b0, model_pc});
      if (!drop_next) begin
        sb_q.push_back({model_pc, mem_data});
        model_pc = model_pc + step_of(mem_data);
      end
      drop_next = 1'b0;
      pend      = auto_rsp;
    end
  endtask

  // Drive just after the rising edge: zero-wait memory response.
  task automatic drv();
    @(posedge clk);
    #1;
    imem_rsp_valid = pend;
    imem_rsp_data  = mem_data;
    pend           = 1'b0;
  endtask

  task automatic wait_accept(input string tag);
    for (int i = 0; i < 20; i++) begin
      smp();
      if (acc) return;
      drv();
    end
    check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_deliver(input string tag);
    for (int i = 0; i < 20; i++) begin
      smp();
      if (popped) return;
      drv();
    end
    check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_iv(input string tag);
    for (int i = 0; i < 20; i++) begin
      smp();
      if (inst_valid) return;
      drv();
    end
    check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_valid"}, {63'b0, imem_req_valid}, 64'd0);
    check({tag, "_inst_valid"}, {63'b0, inst_valid}, 64'd0);
    check({tag, "_trap"}, {63'b0, misalign_trap}, 64'd0);
    check({tag, "_inst_data"}, {32'b0, inst_data}, 64'h13);
    check({tag, "_inst_pc"}, {32'b0, inst_pc}, 64'd0);
    check({tag, "_trap_pc"}, {32'b0, trap_pc}, 64'd0);
    check({tag, "_addr"}, {32'b0, imem_req_addr}, 64'h80);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    inst_ready = 1'b1; mem_data = 32'h0050_0093; model_pc = 32'h80;
    auto_rsp = 1'b1; drop_next = 1'b0; pend = 1'b0;

    // Reset and first fetch
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    @(posedge clk); #1; rst_n = 1'b1;
    smp();
    check("pre_edge_req_valid", {63'b0, imem_req_valid}, 64'd0);
    drv();

    // Straight-line fetch: inst_valid every third cycle
    for (int k = 1; k <= 9; k++) begin
      smp();
      if (k == 1) check("first_req_valid", {63'b0, imem_req_valid}, 64'd1);
      check("iv_cadence", {63'b0, inst_valid}, (k % 3 == 0) ? 64'd1 : 64'd0);
      drv();
    end

    // Backpressure from decode
    inst_ready = 1'b0;
    wait_accept("bp_acc"); drv();
    wait_iv("bp_iv");
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", {63'b0, inst_valid}, 64'd1);
      check("bp_hold_pc", {32'b0, inst_pc}, 64'h8C);
      check("bp_hold_data", {32'b0, inst_data}, 64'h0050_0093);
      check("bp_no_req", {63'b0, imem_req_valid}, 64'd0);
      drv(); smp();
    end

    // Stall does not drop a pending request
    drv(); inst_ready = 1'b1; imem_req_ready = 1'b0;
    smp();
    drv();
    smp();
    check("st_pend", {63'b0, imem_req_valid}, 64'd1);
    drv(); stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp();
      check("st_sticky", {63'b0, imem_req_valid}, 64'd1);
      check("st_addr", {32'b0, imem_req_addr}, {32'b0, model_pc});
      drv();
    end
    stall = 1'b0; imem_req_ready = 1'b1;
    wait_accept("st_acc"); drv();
    wait_deliver("st_del");

    // Redirect during WAIT, stale response must be dropped
    drv(); auto_rsp = 1'b0; drop_next = 1'b1;
    wait_accept("rd_acc"); drv();
    redirect_valid = 1'b1; redirect_target = 32'h200; model_pc = 32'h200;
    smp();
    drv(); redirect_valid = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    smp();
    check("rd_addr", {32'b0, imem_req_addr}, 64'h200);
    check("rd_req_off", {63'b0, imem_req_valid}, 64'd0);
    check("rd_no_trap", {63'b0, misalign_trap}, 64'd0);
    auto_rsp = 1'b1;
    drv();
    wait_accept("rd_acc2"); drv();
    wait_deliver("rd_del");

    // Misaligned redirect withdrawing a pending request
    drv(); imem_req_ready = 1'b0;
    smp();
    check("mis_pend", {63'b0, imem_req_valid}, 64'd1);
    drv(); redirect_valid = 1'b1; redirect_target = 32'h202;
    smp();
    drv(); redirect_valid = 1'b0;
    smp();
    check("mis_withdraw", {63'b0, imem_req_valid}, 64'd0);
`ifdef WAVERV_RVC_EN
    check("mis_trap", {63'b0, misalign_trap}, 64'd0);
    check("mis_addr", {32'b0, imem_req_addr}, 64'h202);
    check("mis_trap_pc", {32'b0, trap_pc}, 64'd0);
    model_pc = 32'h202;
`else
    check("mis_trap", {63'b0, misalign_trap}, 64'd1);
    check("mis_addr", {32'b0, imem_req_addr}, 64'h100);
    check("mis_trap_pc", {32'b0, trap_pc}, 64'h202);
    model_pc = 32'h100;
`endif
    drv();
    smp();
    check("mis_pulse_end", {63'b0, misalign_trap}, 64'd0);
`ifdef WAVERV_RVC_EN
    check("mis_trap_pc_hold", {32'b0, trap_pc}, 64'd0);
`else
    check("mis_trap_pc_hold", {32'b0, trap_pc}, 64'h202);
`endif
    drv(); imem_req_ready = 1'b1;
    wait_accept("mis_acc"); drv();
    wait_deliver("mis_del");

    // Compressed instruction advance
    drv(); mem_data = 32'h0000_4501;
    wait_accept("c_acc"); drv();
    wait_deliver("c_del");
    drv(); mem_data = 32'h0050_0093;
    wait_accept("c_next"); drv();
    wait_deliver("c_del2");

    // PC wrap from the top of the address space
    drv(); imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    smp();
    drv(); redirect_valid = 1'b0; imem_req_ready = 1'b1; model_pc = 32'hFFFF_FFFC;
    wait_accept("wr_acc1"); drv();
    wait_deliver("wr_del1");
    drv();
    wait_accept("wr_acc0");
    check("wr_zero", {32'b0, imem_req_addr}, 64'd0);
    drv();
    wait_deliver("wr_del0");

    // Reset mid-transaction; response right after reset is ignored
    drv(); auto_rsp = 1'b0; drop_next = 1'b1;
    wait_accept("rs_acc"); drv();
    rst_n = 1'b0; stall = 1'b1;
    smp();
    check_reset("rs");
    drv(); rst_n = 1'b1; model_pc = 32'h80; auto_rsp = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    smp();
    check("rs_stall0", {63'b0, imem_req_valid}, 64'd0);
    check("rs_iv0", {63'b0, inst_valid}, 64'd0);
    drv();
    smp();
    check("rs_stall1", {63'b0, imem_req_valid}, 64'd0);
    check("rs_iv1", {63'b0, inst_valid}, 64'd0);
    drv(); stall = 1'b0;
    wait_accept("rs_acc2"); drv();
    wait_deliver("rs_del");
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
